// File: rtl/mips32_mem_arbiter.sv
// Arbitrates the single-port unified memory between IF, MEM and DBG (DBG > MEM > IF) and
// steers 1-cycle read responses back by tag. Optional IF starvation guard: MEM_ARB_STARVE_GUARD_EN.
module mips32_mem_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 10,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halted,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_gnt,
    output logic              mem_rvalid,
    output logic [DATA_W-1:0] mem_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic              dbg_lock,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [0:0] ST_NORMAL     = 1'b0;
    localparam logic [0:0] ST_DBG_LOCKED = 1'b1;

    localparam logic [1:0] TAG_NONE = 2'd0;
    localparam logic [1:0] TAG_IF   = 2'd1;
    localparam logic [1:0] TAG_MEM  = 2'd2;
    localparam logic [1:0] TAG_DBG  = 2'd3;

    logic [0:0] state_q, state_d;
    logic [1:0] tag_q, tag_d;
    logic       if_eff;
    logic       lock_active;
    logic       if_force;

    assign if_eff      = if_req && !halted;
    // Once lock drops, the same cycle already arbitrates normally.
    assign lock_active = (state_q == ST_DBG_LOCKED) && dbg_lock;

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic [2:0] starve_q;

    assign if_force = !lock_active && if_eff && (starve_q == 3'(STARVE_MAX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= 3'd0;
        end else if (if_gnt || !if_req || halted) begin
            starve_q <= 3'd0;
        end else if ((state_q == ST_NORMAL) && (starve_q != 3'(STARVE_MAX))) begin
            starve_q <= starve_q + 3'd1;
        end
    end
`else
    assign if_force = 1'b0;
`endif

    // Grants are held low during reset so every output reads zero while rst=1.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        if_gnt  = 1'b0;
        mem_gnt = 1'b0;
        dbg_gnt = 1'b0;
        if (!rst) begin
            if (lock_active) begin
                dbg_gnt = dbg_req;
            end else if (if_force) begin
                if_gnt = 1'b1;
            end else if (dbg_req) begin
                dbg_gnt = 1'b1;
            end else if (mem_req) begin
                mem_gnt = 1'b1;
            end else if (if_eff) begin
                if_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        ram_en    = if_gnt || mem_gnt || dbg_gnt;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        tag_d     = TAG_NONE;
        if (dbg_gnt) begin
            ram_we    = dbg_we;
            ram_addr  = dbg_addr;
            ram_wdata = dbg_wdata;
            if (!dbg_we) tag_d = TAG_DBG;
        end else if (mem_gnt) begin
            ram_we    = mem_we;
            ram_addr  = mem_addr;
            ram_wdata = mem_wdata;
            if (!mem_we) tag_d = TAG_MEM;
        end else if (if_gnt) begin
            ram_addr  = if_addr;
            tag_d     = TAG_IF;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_NORMAL:     if (dbg_gnt && dbg_lock) state_d = ST_DBG_LOCKED;
            ST_DBG_LOCKED: if (!dbg_lock)           state_d = ST_NORMAL;
            default:                                state_d = ST_NORMAL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_NORMAL;
            tag_q   <= TAG_NONE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q <= state_d;
            tag_q   <= tag_d;
        end
    end

    assign if_rvalid  = (tag_q == TAG_IF);
    assign mem_rvalid = (tag_q == TAG_MEM);
    assign dbg_rvalid = (tag_q == TAG_DBG);
    assign if_rdata   = if_rvalid  ? ram_rdata : '0;
    assign mem_rdata  = mem_rvalid ? ram_rdata : '0;
    assign dbg_rdata  = dbg_rvalid ? ram_rdata : '0;

endmodule
